register_load_sequencer: RTL and testbench

Command-driven initiator for the 16-bit general register's E/FunSel/I load port. It accepts one register operation at a time over a valid/ready command handshake. Byte-sourced loads pull bytes from an 8-bit valid/ready stream, such as a memory read port. It then issues the matching registered E/FunSel/I pulses to the register. It sits between the control unit and the register, so the control unit never sequences the two-byte word loads itself.

---
 rtl/register_load_sequencer_pkg.sv | 44 ++++
 rtl/register_load_sequencer_shadow.sv | 18 +
 rtl/register_load_sequencer.sv | 102 ++++++++++
 tb/tb_register_load_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/register_load_sequencer_pkg.sv
// Shared FunSel/CmdOp encodings, FSM state type and the register update function.
package register_load_sequencer_pkg;

  localparam logic [2:0] FS_DEC = 3'b000;
  localparam logic [2:0] FS_INC = 3'b001;
  localparam logic [2:0] FS_LD  = 3'b010;
  localparam logic [2:0] FS_CLR = 3'b011;
  localparam logic [2:0] FS_ZXT = 3'b100;
  localparam logic [2:0] FS_LDL = 3'b101;
  localparam logic [2:0] FS_LDH = 3'b110;
  localparam logic [2:0] FS_SXT = 3'b111;

  localparam logic [2:0] OP_DEC    = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_LOAD16 = 3'b010;
  localparam logic [2:0] OP_CLR    = 3'b011;
  localparam logic [2:0] OP_LDB_ZX = 3'b100;
  localparam logic [2:0] OP_LDW    = 3'b101;
  localparam logic [2:0] OP_LDB_HI = 3'b110;
  localparam logic [2:0] OP_LDB_SX = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_WAIT_LO = 2'd2,
    S_WAIT_HI = 2'd3
  } state_t;

  function automatic logic [15:0] reg_update(input logic [15:0] q,
                                             input logic [2:0]  fs,
                                             input logic [15:0] i);
    case (fs)
      FS_DEC:  reg_update = q - 16'd1;
      FS_INC:  reg_update = q + 16'd1;
      FS_LD:   reg_update = i;
      FS_CLR:  reg_update = 16'h0000;
      FS_ZXT:  reg_update = {8'h00, i[7:0]};
      FS_LDL:  reg_update = {q[15:8], i[7:0]};
      FS_LDH:  reg_update = {i[7:0], q[7:0]};
      default: reg_update = {{8{i[7]}}, i[7:0]};
    endcase
  endfunction

endpackage

// File: rtl/register_load_sequencer_shadow.sv
// reg_shadow_model: mirrors the general register by applying each RegE pulse.
module reg_shadow_model
  import register_load_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RegE,
  input  logic [2:0]  RegFunSel,
  input  logic [15:0] RegI,
  output logic [15:0] ShadowQ
);

  always_ff @(posedge Clock) begin
    if (Reset)     ShadowQ <= 16'h0000;
    else if (RegE) ShadowQ <= reg_update(ShadowQ, RegFunSel, RegI);
  end

endmodule

// File: rtl/register_load_sequencer.sv
// Sequences single-op and byte-sourced loads onto the register E/FunSel/I port.
// Define REG_LOAD_SEQ_SHADOW_EN to build the ShadowQ tracking model.
module register_load_sequencer
  import register_load_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [2:0]  CmdOp,
  input  logic [15:0] CmdData,
  input  logic        ByteValid,
  output logic        ByteReady,
  input  logic [7:0]  ByteData,
  output logic        RegE,
  output logic [2:0]  RegFunSel,
  output logic [15:0] RegI,
  output logic        Done,
  output logic [15:0] ShadowQ
);

  state_t      state, state_n;
  logic [2:0]  op_q, op_n;
  logic        e_n, done_n;
  logic [2:0]  fs_n;
  logic [15:0] i_n;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_IDLE;
      op_q      <= 3'b000;
      RegE      <= 1'b0;
      RegFunSel <= 3'b000;
      RegI      <= 16'h0000;
      Done      <= 1'b0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      RegE      <= e_n;
      RegFunSel <= fs_n;
      RegI      <= i_n;
      Done      <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    e_n       = 1'b0;
    done_n    = 1'b0;
    fs_n      = RegFunSel;
    i_n       = RegI;
    CmdReady  = (state == S_IDLE) && !Reset;
    ByteReady = ((state == S_WAIT_LO) || (state == S_WAIT_HI)) && !Reset;
    case (state)
      S_IDLE: if (CmdValid && CmdReady) begin
        op_n = CmdOp;
        // op[2] set marks the byte-sourced loads
        if (CmdOp[2]) begin
          state_n = S_WAIT_LO;
        end else begin
          state_n = S_EXEC;
          e_n     = 1'b1;
          done_n  = 1'b1;
          fs_n    = CmdOp;
          i_n     = (CmdOp == OP_LOAD16) ? CmdData : 16'h0000;
        end
      end
      S_EXEC: state_n = S_IDLE;
      S_WAIT_LO: if (ByteValid && ByteReady) begin
        // byte-op codes coincide with the FunSel of their first pulse
        e_n     = 1'b1;
        fs_n    = op_q;
        i_n     = {8'h00, ByteData};
        done_n  = (op_q != OP_LDW);
        state_n = (op_q == OP_LDW) ? S_WAIT_HI : S_IDLE;
      end
      S_WAIT_HI: if (ByteValid && ByteReady) begin
        e_n     = 1'b1;
        fs_n    = FS_LDH;
        i_n     = {8'h00, ByteData};
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef REG_LOAD_SEQ_SHADOW_EN
  reg_shadow_model u_shadow (
    .Clock    (Clock),
    .Reset    (Reset),
    .RegE     (RegE),
    .RegFunSel(RegFunSel),
    .RegI     (RegI),
    .ShadowQ  (ShadowQ)
  );
`else
  assign ShadowQ = 16'h0000;
`endif

endmodule

// File: tb/tb_register_load_sequencer.sv
// Directed bench for register_load_sequencer; expectations are hand-computed.
module tb_register_load_sequencer;
  import register_load_sequencer_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        CmdValid;
  logic        CmdReady;
  logic [2:0]  CmdOp;
  logic [15:0] CmdData;
  logic        ByteValid;
  logic        ByteReady;
  logic [7:0]  ByteData;
  logic        RegE;
  logic [2:0]  RegFunSel;
  logic [15:0] RegI;
  logic        Done;
  logic [15:0] ShadowQ;

  int n_cmp = 0;
  int n_err = 0;

  register_load_sequencer dut (
    .Clock(Clock), .Reset(Reset),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp), .CmdData(CmdData),
    .ByteValid(ByteValid), .ByteReady(ByteReady), .ByteData(ByteData),
    .RegE(RegE), .RegFunSel(RegFunSel), .RegI(RegI), .Done(Done),
    .ShadowQ(ShadowQ)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_shadow(input string tag, input logic [15:0] exp);
`ifdef REG_LOAD_SEQ_SHADOW_EN
    check(tag, ShadowQ, exp);
`else
    check(tag, ShadowQ, 16'h0000);
    if (exp == 16'hxxxx) $display("unreachable");
`endif
  endtask

  task automatic check_pulse(input string tag, input logic [2:0] fs,
                             input logic [15:0] i, input logic done);
    check({tag, "_e"},    {15'd0, RegE}, 16'd1);
    check({tag, "_fs"},   {13'd0, RegFunSel}, {13'd0, fs});
    check({tag, "_i"},    RegI, i);
    check({tag, "_done"}, {15'd0, Done}, {15'd0, done});
  endtask

  // Present a command, wait (bounded) for acceptance, then scramble the bus.
  task automatic send_cmd(input logic [2:0] op, input logic [15:0] data);
    CmdValid = 1'b1; CmdOp = op; CmdData = data;
    for (int k = 0; k < 20 && !CmdReady; k++) tick();
    check("cmd_accept_ready", {15'd0, CmdReady}, 16'd1);
    tick();
    CmdValid = 1'b0; CmdOp = ~op; CmdData = ~data;
  endtask

  task automatic nonbyte(input string tag, input logic [2:0] op, input logic [15:0] data,
                         input logic [15:0] expi);
    send_cmd(op, data);
    check_pulse(tag, op, expi, 1'b1);
    check({tag, "_busy"}, {15'd0, CmdReady}, 16'd0);
    tick();
    check({tag, "_idle_e"}, {15'd0, RegE}, 16'd0);
    check({tag, "_ready"}, {15'd0, CmdReady}, 16'd1);
  endtask

  task automatic give_byte(input logic [7:0] b);
    ByteValid = 1'b1; ByteData = b;
    tick();
    ByteValid = 1'b0; ByteData = 8'h00;
  endtask

  initial begin
    Reset = 1'b1; CmdValid = 1'b0; CmdOp = 3'b000; CmdData = 16'h0000;
    ByteValid = 1'b0; ByteData = 8'h00;
    tick(); tick();
    check("rst_rege",   {15'd0, RegE}, 16'd0);
    check("rst_fs",     {13'd0, RegFunSel}, 16'd0);
    check("rst_regi",   RegI, 16'h0000);
    check("rst_done",   {15'd0, Done}, 16'd0);
    check("rst_cmdrdy", {15'd0, CmdReady}, 16'd0);
    check("rst_bytrdy", {15'd0, ByteReady}, 16'd0);
    check_shadow("rst_shadow", 16'h0000);
    Reset = 1'b0; #1;
    check("post_rst_cmdrdy", {15'd0, CmdReady}, 16'd1);

    nonbyte("clr",  OP_CLR, 16'h5A5A, 16'h0000);
    nonbyte("inc1", OP_INC, 16'h0000, 16'h0000);
    nonbyte("inc2", OP_INC, 16'h0000, 16'h0000);
    nonbyte("inc3", OP_INC, 16'h0000, 16'h0000);
    check_shadow("shadow_3", 16'h0003);

    nonbyte("ld16", OP_LOAD16, 16'hFFFF, 16'hFFFF);
    check_shadow("shadow_ffff", 16'hFFFF);
    nonbyte("incw", OP_INC, 16'h1234, 16'h0000);
    check_shadow("shadow_wrap", 16'h0000);
    nonbyte("dec", OP_DEC, 16'h0000, 16'h0000);
    check_shadow("shadow_dec", 16'hFFFF);
    nonbyte("clr2", OP_CLR, 16'h0000, 16'h0000);

    // LDW with delayed bytes
    send_cmd(OP_LDW, 16'h0000);
    check("ldw_bytrdy", {15'd0, ByteReady}, 16'd1);
    check("ldw_cmdrdy", {15'd0, CmdReady}, 16'd0);
    repeat (5) tick();
    check("ldw_stall_e", {15'd0, RegE}, 16'd0);
    give_byte(8'h34);
    check_pulse("ldw_lo", FS_LDL, 16'h0034, 1'b0);
    tick();
    check("ldw_hi_bytrdy", {15'd0, ByteReady}, 16'd1);
    check("ldw_hi_stall_e", {15'd0, RegE}, 16'd0);
    repeat (4) tick();
    give_byte(8'h12);
    check_pulse("ldw_hi", FS_LDH, 16'h0012, 1'b1);
    tick();
    check_shadow("shadow_1234", 16'h1234);

    send_cmd(OP_LDB_SX, 16'h0000);
    give_byte(8'h80);
    check_pulse("ldsx", FS_SXT, 16'h0080, 1'b1);
    tick();
    check_shadow("shadow_ff80", 16'hFF80);

    send_cmd(OP_LDB_ZX, 16'h0000);
    give_byte(8'h80);
    check_pulse("ldzx", FS_ZXT, 16'h0080, 1'b1);
    tick();
    check_shadow("shadow_0080", 16'h0080);

    // Byte offered while idle must not be consumed early
    ByteValid = 1'b1; ByteData = 8'hAA;
    tick(); tick();
    check("idle_bytrdy", {15'd0, ByteReady}, 16'd0);
    check("idle_e", {15'd0, RegE}, 16'd0);
    send_cmd(OP_LDB_HI, 16'h0000);
    check("ldhi_e_wait", {15'd0, RegE}, 16'd0);
    check("ldhi_bytrdy", {15'd0, ByteReady}, 16'd1);
    tick();
    ByteValid = 1'b0;
    check_pulse("ldhi", FS_LDH, 16'h00AA, 1'b1);
    tick();
    check_shadow("shadow_aa80", 16'hAA80);

    // Reset while waiting for the LDW high byte
    send_cmd(OP_LDW, 16'h0000);
    give_byte(8'h55);
    check_pulse("rldw_lo", FS_LDL, 16'h0055, 1'b0);
    tick();
    check_shadow("shadow_aa55", 16'hAA55);
    Reset = 1'b1; ByteValid = 1'b1; ByteData = 8'h66; #1;
    check("mid_rst_cmdrdy", {15'd0, CmdReady}, 16'd0);
    check("mid_rst_bytrdy", {15'd0, ByteReady}, 16'd0);
    tick();
    check("mid_rst_e", {15'd0, RegE}, 16'd0);
    check("mid_rst_done", {15'd0, Done}, 16'd0);
    Reset = 1'b0; ByteValid = 1'b0; #1;
    check("after_rst_cmdrdy", {15'd0, CmdReady}, 16'd1);
    tick();
    check("after_rst_e", {15'd0, RegE}, 16'd0);
    check("after_rst_bytrdy", {15'd0, ByteReady}, 16'd0);
    check_shadow("shadow_rst0", 16'h0000);
    nonbyte("inc_after", OP_INC, 16'h0000, 16'h0000);
    check_shadow("shadow_0001", 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
